// File: rtl/ppu_pkg.sv
// Shared definitions for the MEM-stage data-memory path: RAM_CTRL field layout,
// access size codes and controller state encoding.
package ppu_pkg;

  localparam int RC_E     = 0;
  localparam int RC_RW    = 1;
  localparam int RC_SZ_LO = 2;
  localparam int RC_SZ_HI = 3;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane steering: byte enables and replicated store data, zero-extended
// load extraction and the alignment check. Purely combinational.
module mem_lane_align
  import ppu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] rb,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic        misalign
);

  always_comb begin
    be       = 4'b1111;
    wdata    = rb;
    ldata    = rdata;
    misalign = 1'b0;
    case (size_e'(size))
      SZ_BYTE: begin
        be    = 4'b1000 >> off;
        wdata = {4{rb[7:0]}};
        case (off)
          2'd0:    ldata = {24'b0, rdata[31:24]};
          2'd1:    ldata = {24'b0, rdata[23:16]};
          2'd2:    ldata = {24'b0, rdata[15:8]};
          default: ldata = {24'b0, rdata[7:0]};
        endcase
      end
      SZ_HALF: begin
        be       = off[1] ? 4'b0011 : 4'b1100;
        wdata    = {2{rb[15:0]}};
        ldata    = off[1] ? {16'b0, rdata[15:0]} : {16'b0, rdata[31:16]};
        misalign = off[0];
      end
      // reserved size code behaves as a word access
      default: begin
        be       = 4'b1111;
        wdata    = rb;
        ldata    = rdata;
        misalign = |off;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: turns EX/MEM load/store fields into a req/ack data-memory
// transaction, stalls the pipeline while it is outstanding, and registers MEM/WB fields.
module mem_access_ctrl
  import ppu_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [31:0]       MEM_RB_in,
  input  logic [31:0]       MEM_ALU_OUT_in,
  input  logic [4:0]        MEM_RD_in,
  input  logic [3:0]        MEM_RAM_CTRL_in,
  input  logic              MEM_L_in,
  input  logic              MEM_RF_LE_in,
  input  logic              DMEM_ACK,
  input  logic [31:0]       DMEM_RDATA,
  output logic              DMEM_REQ,
  output logic              DMEM_WE,
  output logic [ADDR_W-1:0] DMEM_ADDR,
  output logic [31:0]       DMEM_WDATA,
  output logic [3:0]        DMEM_BE,
  output logic              MEM_STALL,
  output logic [4:0]        WB_RD_out,
  output logic              WB_RF_LE_out,
  output logic [31:0]       WB_DATA_out,
  output logic              MISALIGN_out,
  output logic              BUS_ERR_out
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      cap;
  logic             berr_seen;

  logic        acc, rw, mis, timeout_hit;
  logic [3:0]  be;
  logic [31:0] wdata, ldata;

  assign acc         = MEM_RAM_CTRL_in[RC_E];
  assign rw          = MEM_RAM_CTRL_in[RC_RW];
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  // EX/MEM is frozen by the stall, so the live inputs stay valid for the whole access
  mem_lane_align u_align (
    .size     (MEM_RAM_CTRL_in[RC_SZ_HI:RC_SZ_LO]),
    .off      (MEM_ALU_OUT_in[1:0]),
    .rb       (MEM_RB_in),
    .rdata    (DMEM_RDATA),
    .be       (be),
    .wdata    (wdata),
    .ldata    (ldata),
    .misalign (mis)
  );

  always_ff @(posedge clk) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    MEM_STALL = 1'b0;
    case (state)
      ST_IDLE: if (acc && !mis) begin
        MEM_STALL = 1'b1;
        state_nx  = ST_BUSY;
      end
      ST_BUSY: begin
        MEM_STALL = 1'b1;
        if (DMEM_ACK || timeout_hit) state_nx = ST_DONE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      DMEM_REQ     <= 1'b0;
      DMEM_WE      <= 1'b0;
      DMEM_ADDR    <= '0;
      DMEM_WDATA   <= '0;
      DMEM_BE      <= '0;
      WB_RD_out    <= '0;
      WB_RF_LE_out <= 1'b0;
      WB_DATA_out  <= '0;
      MISALIGN_out <= 1'b0;
      BUS_ERR_out  <= 1'b0;
      cnt          <= '0;
      cap          <= '0;
      berr_seen    <= 1'b0;
    end else begin
      MISALIGN_out <= 1'b0;
      BUS_ERR_out  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!acc) begin
            WB_DATA_out  <= MEM_ALU_OUT_in;
            WB_RD_out    <= MEM_RD_in;
            WB_RF_LE_out <= MEM_RF_LE_in;
          end else if (mis) begin
            MISALIGN_out <= 1'b1;
            WB_RD_out    <= MEM_RD_in;
            WB_RF_LE_out <= 1'b0;
          end else begin
            DMEM_REQ   <= 1'b1;
            DMEM_WE    <= rw;
            DMEM_ADDR  <= {MEM_ALU_OUT_in[ADDR_W-1:2], 2'b00};
            DMEM_WDATA <= wdata;
            DMEM_BE    <= be;
            cnt        <= '0;
            berr_seen  <= 1'b0;
          end
        end
        ST_BUSY: begin
          cnt <= cnt + CNT_W'(1);
          // ACK takes priority over a timeout landing in the same cycle
          if (DMEM_ACK) begin
            DMEM_REQ <= 1'b0;
            DMEM_WE  <= 1'b0;
            cap      <= ldata;
          end else if (timeout_hit) begin
            DMEM_REQ     <= 1'b0;
            BUS_ERR_out  <= 1'b1;
            WB_RF_LE_out <= 1'b0;
            berr_seen    <= 1'b1;
          end
        end
        ST_DONE: begin
          WB_DATA_out  <= MEM_L_in ? cap : MEM_ALU_OUT_in;
          WB_RD_out    <= MEM_RD_in;
          WB_RF_LE_out <= MEM_RF_LE_in & ~berr_seen;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, reset-during-busy sequence and
// randomized transactions checked against a lane/timeout reference model.
module tb_mem_access_ctrl;

  localparam int TO = 16;

  logic        clk, Reset;
  logic [31:0] MEM_RB_in, MEM_ALU_OUT_in, DMEM_RDATA;
  logic [4:0]  MEM_RD_in;
  logic [3:0]  MEM_RAM_CTRL_in;
  logic        MEM_L_in, MEM_RF_LE_in, DMEM_ACK;
  logic        DMEM_REQ, DMEM_WE, MEM_STALL;
  logic [8:0]  DMEM_ADDR;
  logic [31:0] DMEM_WDATA, WB_DATA_out;
  logic [3:0]  DMEM_BE;
  logic [4:0]  WB_RD_out;
  logic        WB_RF_LE_out, MISALIGN_out, BUS_ERR_out;

  mem_access_ctrl #(.ADDR_W(9), .TIMEOUT(TO)) dut (
    .clk(clk), .Reset(Reset),
    .MEM_RB_in(MEM_RB_in), .MEM_ALU_OUT_in(MEM_ALU_OUT_in), .MEM_RD_in(MEM_RD_in),
    .MEM_RAM_CTRL_in(MEM_RAM_CTRL_in), .MEM_L_in(MEM_L_in), .MEM_RF_LE_in(MEM_RF_LE_in),
    .DMEM_ACK(DMEM_ACK), .DMEM_RDATA(DMEM_RDATA),
    .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
    .DMEM_WDATA(DMEM_WDATA), .DMEM_BE(DMEM_BE), .MEM_STALL(MEM_STALL),
    .WB_RD_out(WB_RD_out), .WB_RF_LE_out(WB_RF_LE_out), .WB_DATA_out(WB_DATA_out),
    .MISALIGN_out(MISALIGN_out), .BUS_ERR_out(BUS_ERR_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] alu, rb;
    logic [4:0]  rd;
    logic        l, rf_le;
    logic [31:0] rdata;
    int          ack_at;      // BUSY cycle carrying ACK; 0 = never
    int          exp_stall;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_wb_data;
    logic        exp_wb_le, exp_mis, exp_berr, chk_data;
  } vec_t;

  int cmp_n = 0;
  int err_n = 0;

  logic [31:0] m_data;
  logic        m_known;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [3:0] ctrl, input logic [31:0] alu, rb,
                               input logic [4:0] rd, input logic l, rf_le,
                               input logic [31:0] rdata, input int ack_at, exp_stall,
                               input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                               exp_wb_data, input logic exp_wb_le, exp_mis, exp_berr);
    vec_t v;
    v.ctrl = ctrl; v.alu = alu; v.rb = rb; v.rd = rd; v.l = l; v.rf_le = rf_le;
    v.rdata = rdata; v.ack_at = ack_at; v.exp_stall = exp_stall; v.exp_be = exp_be;
    v.exp_wdata = exp_wdata; v.exp_wb_data = exp_wb_data; v.exp_wb_le = exp_wb_le;
    v.exp_mis = exp_mis; v.exp_berr = exp_berr; v.chk_data = 1'b1;
    return v;
  endfunction

  // Reference model: lane arithmetic from offsets, stall length from the ACK schedule
  function automatic vec_t model(input logic [3:0] ctrl, input logic [31:0] alu, rb,
                                 input logic [4:0] rd, input logic l, rf_le,
                                 input logic [31:0] rdata, input int ack_at);
    vec_t v;
    int off, sz;
    logic [31:0] ld;
    bit mis, to;
    off = int'(alu & 32'h3);
    sz  = int'(ctrl[3:2]);
    v.ctrl = ctrl; v.alu = alu; v.rb = rb; v.rd = rd; v.l = l; v.rf_le = rf_le;
    v.rdata = rdata; v.ack_at = ack_at; v.exp_berr = 1'b0; v.chk_data = 1'b1;
    if (sz == 0) begin
      v.exp_be = 4'(8 >> off); v.exp_wdata = rb[7:0] * 32'h0101_0101;
      ld = (rdata >> (8 * (3 - off))) & 32'hFF; mis = 0;
    end else if (sz == 1) begin
      v.exp_be = (off == 0) ? 4'hC : 4'h3; v.exp_wdata = rb[15:0] * 32'h0001_0001;
      ld = (rdata >> (16 - 8 * off)) & 32'hFFFF; mis = (off % 2) != 0;
    end else begin
      v.exp_be = 4'hF; v.exp_wdata = rb; ld = rdata; mis = off != 0;
    end
    to = !(ack_at >= 1 && ack_at <= TO);
    if (!ctrl[0]) begin
      v.exp_stall = 0; v.exp_mis = 0; v.exp_wb_le = rf_le;
      m_data = alu; m_known = 1;
    end else if (mis) begin
      v.exp_stall = 0; v.exp_mis = 1; v.exp_wb_le = 0;
    end else begin
      v.exp_mis = 0; v.exp_stall = to ? TO + 1 : ack_at + 1;
      v.exp_berr = to; v.exp_wb_le = rf_le & !to;
      if (!l) begin m_data = alu; m_known = 1; end
      else if (to) m_known = 0;
      else begin m_data = ld; m_known = 1; end
    end
    v.exp_wb_data = m_data;
    v.chk_data = m_known;
    return v;
  endfunction

  // Entered and left at a negedge with the controller in IDLE
  task automatic run_txn(input vec_t v);
    int busy;
    MEM_RAM_CTRL_in = v.ctrl; MEM_ALU_OUT_in = v.alu; MEM_RB_in = v.rb;
    MEM_RD_in = v.rd; MEM_L_in = v.l; MEM_RF_LE_in = v.rf_le; DMEM_ACK = 1'b0;
    #1;
    chk("stall_idle", MEM_STALL, v.exp_stall != 0);
    if (v.exp_stall == 0) begin
      @(negedge clk);
      chk("req_idle", DMEM_REQ, 0);
      chk("stall_after", MEM_STALL, 0);
      chk("misalign", MISALIGN_out, v.exp_mis);
      chk("wb_rd", WB_RD_out, v.rd);
      chk("wb_le", WB_RF_LE_out, v.exp_wb_le);
      if (v.chk_data) chk("wb_data", WB_DATA_out, v.exp_wb_data);
      return;
    end
    @(negedge clk);
    chk("req", DMEM_REQ, 1);
    chk("we", DMEM_WE, v.ctrl[1]);
    chk("addr", DMEM_ADDR, v.alu & 32'h1FC);
    chk("be", DMEM_BE, v.exp_be);
    chk("wdata", DMEM_WDATA, v.exp_wdata);
    chk("misalign_busy", MISALIGN_out, 0);
    busy = 0;
    while (MEM_STALL && busy < 40) begin
      busy++;
      chk("req_busy", DMEM_REQ, 1);
      if (busy == v.ack_at) begin DMEM_ACK = 1'b1; DMEM_RDATA = v.rdata; end
      else begin DMEM_ACK = 1'b0; DMEM_RDATA = $urandom; end
      @(negedge clk);
      DMEM_ACK = 1'b0;
    end
    chk("stall_cycles", busy + 1, v.exp_stall);
    chk("req_done", DMEM_REQ, 0);
    chk("bus_err", BUS_ERR_out, v.exp_berr);
    @(negedge clk);
    chk("bus_err_end", BUS_ERR_out, 0);
    chk("wb_rd", WB_RD_out, v.rd);
    chk("wb_le", WB_RF_LE_out, v.exp_wb_le);
    if (v.chk_data) chk("wb_data", WB_DATA_out, v.exp_wb_data);
  endtask

  vec_t tbl[12];

  initial begin
    //            ctrl     alu           rb            rd  l  le rdata         ack st be     wdata         wb_data       le mis berr
    tbl[0]  = mkv(4'b0000, 32'h0000_1234, 32'h0,        5,  0, 1, 32'h0,        0, 0, 4'h0, 32'h0,        32'h0000_1234, 1, 0, 0);
    tbl[1]  = mkv(4'b1011, 32'h0000_0010, 32'hDEAD_BEEF, 7, 0, 0, 32'h0,        1, 2, 4'hF, 32'hDEAD_BEEF, 32'h0000_0010, 0, 0, 0);
    tbl[2]  = mkv(4'b0001, 32'h0000_0013, 32'h0,        9,  1, 1, 32'h1122_3344, 3, 4, 4'h1, 32'h0,        32'h0000_0044, 1, 0, 0);
    tbl[3]  = mkv(4'b0101, 32'h0000_0021, 32'h0,        10, 1, 1, 32'h0,        0, 0, 4'h0, 32'h0,        32'h0000_0044, 0, 1, 0);
    tbl[4]  = mkv(4'b1001, 32'h0000_0040, 32'h55,       11, 0, 1, 32'h0,        0, 17, 4'hF, 32'h55,      32'h0000_0040, 0, 0, 1);
    tbl[5]  = mkv(4'b0111, 32'h0000_01F6, 32'h0000_ABCD, 1, 0, 0, 32'h0,        2, 3, 4'h3, 32'hABCD_ABCD, 32'h0000_01F6, 0, 0, 0);
    tbl[6]  = mkv(4'b0101, 32'h0000_0100, 32'h0,        2,  1, 1, 32'hCAFE_1234, 1, 2, 4'hC, 32'h0,        32'h0000_CAFE, 1, 0, 0);
    tbl[7]  = mkv(4'b1101, 32'h0000_00F8, 32'h1357_9BDF, 8, 1, 1, 32'h89AB_CDEF, 1, 2, 4'hF, 32'h1357_9BDF, 32'h89AB_CDEF, 1, 0, 0);
    tbl[8]  = mkv(4'b0011, 32'h0000_0005, 32'h0000_00A5, 12, 0, 0, 32'h0,       2, 3, 4'h4, 32'hA5A5_A5A5, 32'h0000_0005, 0, 0, 0);
    tbl[9]  = mkv(4'b1001, 32'h0000_0102, 32'h0,        4,  0, 1, 32'h0,        0, 0, 4'h0, 32'h0,        32'h0000_0005, 0, 1, 0);
    tbl[10] = mkv(4'b1001, 32'h0000_0080, 32'h0,        13, 1, 1, 32'h0BAD_F00D, 16, 17, 4'hF, 32'h0,     32'h0BAD_F00D, 1, 0, 0);
    tbl[11] = mkv(4'b1110, 32'hFFFF_FFFF, 32'h0,        31, 0, 1, 32'h0,        0, 0, 4'h0, 32'h0,        32'hFFFF_FFFF, 1, 0, 0);

    Reset = 1'b1; MEM_RB_in = '0; MEM_ALU_OUT_in = '0; MEM_RD_in = '0;
    MEM_RAM_CTRL_in = '0; MEM_L_in = 0; MEM_RF_LE_in = 0; DMEM_ACK = 0; DMEM_RDATA = '0;
    repeat (2) @(negedge clk);
    chk("rst_req", DMEM_REQ, 0);    chk("rst_we", DMEM_WE, 0);
    chk("rst_addr", DMEM_ADDR, 0);  chk("rst_wdata", DMEM_WDATA, 0);
    chk("rst_be", DMEM_BE, 0);      chk("rst_stall", MEM_STALL, 0);
    chk("rst_wb_rd", WB_RD_out, 0); chk("rst_wb_le", WB_RF_LE_out, 0);
    chk("rst_wb_data", WB_DATA_out, 0);
    chk("rst_mis", MISALIGN_out, 0); chk("rst_berr", BUS_ERR_out, 0);
    Reset = 1'b0;

    for (int i = 0; i < 12; i++) run_txn(tbl[i]);

    // Reset landing in the second BUSY cycle, then a stray ACK while idle
    MEM_RAM_CTRL_in = 4'b1001; MEM_ALU_OUT_in = 32'h30; MEM_RD_in = 6;
    MEM_L_in = 1; MEM_RF_LE_in = 1;
    @(negedge clk);
    chk("r6_req_busy1", DMEM_REQ, 1);
    @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    chk("r6_req", DMEM_REQ, 0);       chk("r6_wb_rd", WB_RD_out, 0);
    chk("r6_wb_le", WB_RF_LE_out, 0); chk("r6_wb_data", WB_DATA_out, 0);
    chk("r6_berr", BUS_ERR_out, 0);   chk("r6_mis", MISALIGN_out, 0);
    Reset = 1'b0; MEM_RAM_CTRL_in = 4'b0000; MEM_ALU_OUT_in = 32'h77; MEM_RD_in = 3;
    MEM_RF_LE_in = 1; DMEM_ACK = 1'b1; DMEM_RDATA = 32'hFFFF_0000;
    #1 chk("r6_stall", MEM_STALL, 0);
    @(negedge clk);
    DMEM_ACK = 1'b0;
    chk("r6_late_req", DMEM_REQ, 0);  chk("r6_late_berr", BUS_ERR_out, 0);
    chk("r6_late_data", WB_DATA_out, 32'h77);
    chk("r6_late_rd", WB_RD_out, 3);  chk("r6_late_le", WB_RF_LE_out, 1);
    m_data = 32'h77; m_known = 1'b1;

    for (int i = 0; i < 40; i++) begin
      logic [3:0] c;
      int r, ack;
      c = 4'($urandom);
      c[0] = ($urandom_range(0, 4) != 0);
      r = $urandom_range(0, 7);
      ack = (r == 7) ? 0 : (r == 6) ? TO : r + 1;
      run_txn(model(c, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
                    $urandom, ack));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
